// File: rtl/dadda_mac_if.sv
// Handshake bundle between the DADDA multiplier/host side and the MAC accumulator.
// The master drives run control and products; the slave (accumulator) returns readiness and results.
interface dadda_mac_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
);
  logic              start;
  logic [CNT_W-1:0]  len;
  logic [PROD_W-1:0] prod_in;
  logic              prod_valid;
  logic              prod_ready;
  logic [ACC_W-1:0]  acc_out;
  logic              res_valid;
  logic              res_ready;
  logic              busy;
  logic              overflow;

  modport master (
    output start, len, prod_in, prod_valid, res_ready,
    input  prod_ready, acc_out, res_valid, busy, overflow
  );

  modport slave (
    input  start, len, prod_in, prod_valid, res_ready,
    output prod_ready, acc_out, res_valid, busy, overflow
  );
endinterface

// File: rtl/dadda_mac_accumulator.sv
// Accumulates a programmed count of multiplier products into an ACC_W-bit sum and hands it off.
// Define MAC_SAT_EN to clamp the sum at all-ones on carry-out instead of wrapping.
module dadda_mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int CNT_W  = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  dadda_mac_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   acc_out_q, acc_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               res_vld_q, busy_q;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   acc_next;
  logic               xfer;

  // One extra bit so the carry-out is visible for overflow detection.
  assign sum  = {1'b0, acc_q} + {{(ACC_W+1-PROD_W){1'b0}}, bus.prod_in};
  assign xfer = (state_q == ACCUM) && bus.prod_valid;

`ifdef MAC_SAT_EN
  // Once clamped, any further add carries again, so the clamp holds for the rest of the run.
  assign acc_next = sum[ACC_W] ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  assign acc_next = sum[ACC_W-1:0];
`endif

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    acc_out_d = acc_out_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          ovf_d = 1'b0;
          if (bus.len != '0) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = bus.len;
          end else begin
            state_d   = DONE;
            acc_out_d = '0;
          end
        end
      end
      ACCUM: begin
        if (xfer) begin
          acc_d = acc_next;
          cnt_d = cnt_q - CNT_W'(1);
          if (sum[ACC_W]) ovf_d = 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            state_d   = DONE;
            acc_out_d = acc_next;
          end
        end
      end
      DONE: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      acc_out_q <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      res_vld_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      acc_out_q <= acc_out_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      res_vld_q <= (state_d == DONE);
      busy_q    <= (state_d != IDLE);
    end
  end

  assign bus.prod_ready = (state_q == ACCUM);
  assign bus.acc_out    = acc_out_q;
  assign bus.res_valid  = res_vld_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_dadda_mac_accumulator.sv
// Directed bench for dadda_mac_accumulator: a 24-bit instance for runs and corner cases,
// and a 17-bit instance for wrap/saturate behaviour.
module tb_dadda_mac_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  dadda_mac_if #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) bus ();
  dadda_mac_if #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) bus17 ();

  dadda_mac_accumulator #(.PROD_W(16), .ACC_W(24), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave)
  );
  dadda_mac_accumulator #(.PROD_W(16), .ACC_W(17), .CNT_W(8)) dut17 (
    .clk(clk), .rst_n(rst_n), .bus(bus17.slave)
  );

  typedef struct {
    logic [7:0]       len;
    logic [3:0][15:0] p;
    logic [23:0]      acc;
    logic             ov;
  } vec_t;

  vec_t vecs[5];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(int idx);
    vec_t v;
    v = vecs[idx];
    bus.start = 1'b1;
    bus.len   = v.len;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < int'(v.len); i++) begin
      check($sformatf("v%0d_ready%0d", idx, i), {31'd0, bus.prod_ready}, 32'd1);
      bus.prod_valid = 1'b1;
      bus.prod_in    = v.p[i];
      step();
    end
    bus.prod_valid = 1'b0;
    check($sformatf("v%0d_res_valid", idx), {31'd0, bus.res_valid}, 32'd1);
    check($sformatf("v%0d_prod_ready", idx), {31'd0, bus.prod_ready}, 32'd0);
    check($sformatf("v%0d_acc_out", idx), {8'd0, bus.acc_out}, {8'd0, v.acc});
    check($sformatf("v%0d_overflow", idx), {31'd0, bus.overflow}, {31'd0, v.ov});
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check($sformatf("v%0d_release", idx), {30'd0, bus.res_valid, bus.busy}, 32'd0);
  endtask

  initial begin
    logic [16:0] exp17;

    vecs[0].len = 8'd3; vecs[0].p = {16'h0000, 16'h0100, 16'h0010, 16'h0001};
    vecs[0].acc = 24'h000111; vecs[0].ov = 1'b0;
    vecs[1].len = 8'd1; vecs[1].p = {16'h0000, 16'h0000, 16'h0000, 16'hFFFF};
    vecs[1].acc = 24'h00FFFF; vecs[1].ov = 1'b0;
    vecs[2].len = 8'd4; vecs[2].p = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    vecs[2].acc = 24'h03FFFC; vecs[2].ov = 1'b0;
    vecs[3].len = 8'd0; vecs[3].p = '0;
    vecs[3].acc = 24'h000000; vecs[3].ov = 1'b0;
    vecs[4].len = 8'd2; vecs[4].p = {16'h0000, 16'h0000, 16'h0001, 16'h1234};
    vecs[4].acc = 24'h001235; vecs[4].ov = 1'b0;

    bus.start = 1'b0; bus.len = '0; bus.prod_in = '0; bus.prod_valid = 1'b0; bus.res_ready = 1'b0;
    bus17.start = 1'b0; bus17.len = '0; bus17.prod_in = '0; bus17.prod_valid = 1'b0; bus17.res_ready = 1'b0;

    // Reset state
    step(); step();
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_res_valid", {31'd0, bus.res_valid}, 32'd0);
    check("rst_prod_ready", {31'd0, bus.prod_ready}, 32'd0);
    check("rst_acc_out", {8'd0, bus.acc_out}, 32'd0);
    check("rst_overflow", {31'd0, bus.overflow}, 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 5; i++) run_vec(i);

    // Gapped valid pattern 1,0,0,1 then a stalled consumer
    bus.start = 1'b1; bus.len = 8'd2; step(); bus.start = 1'b0;
    bus.prod_in = 16'hFE01;
    bus.prod_valid = 1'b1; step();
    bus.prod_valid = 1'b0; step(); step();
    check("gap_mid_busy", {30'd0, bus.busy, bus.res_valid}, 32'd2);
    bus.prod_valid = 1'b1; step();
    bus.prod_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_acc%0d", i), {8'd0, bus.acc_out}, 32'h01FC02);
      check($sformatf("hold_vld%0d", i), {31'd0, bus.res_valid}, 32'd1);
      step();
    end
    bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;

    // 17-bit instance: 3 x 0xFE01 carries out of bit 16
`ifdef MAC_SAT_EN
    exp17 = 17'h1FFFF;
`else
    exp17 = 17'h0FA03;
`endif
    bus17.start = 1'b1; bus17.len = 8'd3; step(); bus17.start = 1'b0;
    bus17.prod_in = 16'hFE01; bus17.prod_valid = 1'b1;
    step(); step(); step();
    bus17.prod_valid = 1'b0;
    check("w17_res_valid", {31'd0, bus17.res_valid}, 32'd1);
    check("w17_acc_out", {15'd0, bus17.acc_out}, {15'd0, exp17});
    check("w17_overflow", {31'd0, bus17.overflow}, 32'd1);
    bus17.res_ready = 1'b1; step(); bus17.res_ready = 1'b0;
    bus17.start = 1'b1; bus17.len = 8'd1; step(); bus17.start = 1'b0;
    bus17.prod_in = 16'h0001; bus17.prod_valid = 1'b1; step(); bus17.prod_valid = 1'b0;
    check("w17_clean_acc", {15'd0, bus17.acc_out}, 32'd1);
    check("w17_ovf_cleared", {31'd0, bus17.overflow}, 32'd0);
    bus17.res_ready = 1'b1; step(); bus17.res_ready = 1'b0;

    // Reset mid-run drops the partial sum
    bus.start = 1'b1; bus.len = 8'd4; step(); bus.start = 1'b0;
    bus.prod_in = 16'h0003; bus.prod_valid = 1'b1; step();
    bus.prod_valid = 1'b0; rst_n = 1'b0; step();
    check("mrst_state", {29'd0, bus.busy, bus.res_valid, bus.prod_ready}, 32'd0);
    check("mrst_acc_out", {8'd0, bus.acc_out}, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("mrst_idle%0d", i), {30'd0, bus.busy, bus.res_valid}, 32'd0);
    end
    bus.start = 1'b1; bus.len = 8'd1; step(); bus.start = 1'b0;
    bus.prod_in = 16'h0005; bus.prod_valid = 1'b1; step(); bus.prod_valid = 1'b0;
    check("post_rst_valid", {31'd0, bus.res_valid}, 32'd1);
    check("post_rst_acc", {8'd0, bus.acc_out}, 32'h000005);

    // start together with res_ready in DONE must not launch a run
    bus.start = 1'b1; bus.len = 8'd2; bus.res_ready = 1'b1; step();
    bus.start = 1'b0; bus.res_ready = 1'b0;
    check("done_start_idle", {29'd0, bus.busy, bus.res_valid, bus.prod_ready}, 32'd0);
    step();
    check("done_start_stay", {29'd0, bus.busy, bus.res_valid, bus.prod_ready}, 32'd0);
    check("idle_keeps_acc", {8'd0, bus.acc_out}, 32'h000005);

    // start during ACCUM is ignored; count is unaffected
    bus.start = 1'b1; bus.len = 8'd2; step();
    bus.len = 8'd5;
    bus.prod_in = 16'h0100; bus.prod_valid = 1'b1; step();
    check("accum_start_mid", {30'd0, bus.busy, bus.res_valid}, 32'd2);
    bus.prod_in = 16'h0023; step();
    bus.start = 1'b0; bus.prod_valid = 1'b0;
    check("accum_start_done", {31'd0, bus.res_valid}, 32'd1);
    check("accum_start_acc", {8'd0, bus.acc_out}, 32'h000123);
    bus.res_ready = 1'b1; step(); bus.res_ready = 1'b0;
    check("final_idle", {30'd0, bus.busy, bus.res_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
